// File: rtl/max_scan_ctrl_pkg.sv
// Shared definitions for the sequential frame max-finder:
// FSM state encoding and default frame geometry.
package max_scan_ctrl_pkg;

   // Frame controller states: collect samples, scan buffer, present result.
   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default frame geometry: samples per frame, sample width, index width.
   localparam int N_DEF  = 12;
   localparam int W_DEF  = 12;
   localparam int IW_DEF = 4;

endpackage

// File: rtl/max_scan_ctrl_max_cmp.sv
// Single unsigned comparator shared across all scan cycles.
// a_i is the candidate sample, b_i the incumbent maximum.
module max_cmp #(
   parameter int W = 12
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         gt_o,
   output logic [W-1:0] max_o
);

   // Strict compare so that on a tie the incumbent (lower index) is kept.
   always_comb begin
      gt_o  = (a_i > b_i);
      max_o = gt_o ? a_i : b_i;
   end

endmodule

// File: rtl/max_scan_ctrl.sv
// Sequential max-finder: buffers a frame of N unsigned samples, then walks
// the buffer with one shared comparator (one compare per cycle) and presents
// the frame maximum and its index over a valid/ready result interface.
module max_scan_ctrl
   import max_scan_ctrl_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int W  = W_DEF,
   parameter int IW = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_max,
   output logic [IW-1:0] out_index,
   output logic          busy
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   k_q, k_d;
   logic [W-1:0]    max_q, max_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    buf_q [N];
   logic            buf_we;
   logic [W-1:0]    cand;
   logic            cmp_gt;
   logic [W-1:0]    cmp_max;

   assign cand = buf_q[k_q];

   max_cmp #(.W(W)) u_cmp (
      .a_i   (cand),
      .b_i   (max_q),
      .gt_o  (cmp_gt),
      .max_o (cmp_max)
   );

   // Next-state and datapath update: load, scan, then hold result until taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      max_d   = max_q;
      idx_d   = idx_q;
      buf_we  = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               buf_we = 1'b1;
               // First sample seeds the incumbent so the scan can start at k=1.
               if (cnt_q == '0) begin
                  max_d = in_data;
                  idx_d = '0;
               end
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  k_d     = IW'(1);
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
         SCAN: begin
            if (cmp_gt) begin
               max_d = cmp_max;
               idx_d = k_q;
            end
            // k stops at N-1; the final compare and the move to DONE coincide.
            if (k_q == LAST) begin
               state_d = DONE;
            end else begin
               k_d = k_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // State and scan registers; reset discards any partial frame or result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         k_q     <= '0;
         max_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
      end
   end

   // Sample buffer; contents are don't-care after reset so it is not cleared.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[cnt_q] <= in_data;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SCAN) || (state_q == DONE);
   assign out_max   = max_q;
   assign out_index = idx_q;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Self-checking bench for max_scan_ctrl: directed and randomized frames
// compared against a plain-arithmetic frame-max reference model.
module tb_max_scan_ctrl;

   localparam int N  = 12;
   localparam int W  = 12;
   localparam int IW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_max;
   logic [IW-1:0] out_index;
   logic          busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [W-1:0] frame [N];

   max_scan_ctrl #(.N(N), .W(W), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_index (out_index),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: largest value in the frame, first occurrence wins ties.
   task automatic model(output logic [W-1:0] m, output int idx);
      int best;
      best = -1;
      idx  = 0;
      for (int i = 0; i < N; i++) begin
         if (int'(frame[i]) > best) begin
            best = int'(frame[i]);
            idx  = i;
         end
      end
      m = W'(best);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends the frame (gap_pct<0: two idle cycles between beats), waits for
   // the result, holds out_ready low for 'hold' cycles, then takes it.
   task automatic run_frame(input string name, input int gap_pct, input int hold);
      logic [W-1:0] exp_max;
      int           exp_idx;
      int           lat;
      model(exp_max, exp_idx);
      out_ready = (hold == 0);
      for (int i = 0; i < N; i++) begin
         if (gap_pct < 0) begin
            if (i > 0) begin
               in_valid = 1'b0; in_data = W'($urandom); tick();
               in_valid = 1'b0; in_data = W'($urandom); tick();
            end
         end else begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
               in_valid = 1'b0; in_data = W'($urandom); tick();
            end
         end
         in_valid = 1'b1;
         in_data  = frame[i];
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s.in_ready beat %0d: got %b want 1", name, i, in_ready);
         end
         tick();
      end
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      n_cmp++;
      if (lat !== N - 1) begin
         n_fail++;
         $display("FAIL %s.latency: got %0d want %0d", name, lat, N - 1);
      end
      n_cmp++;
      if (out_max !== exp_max || out_index !== IW'(exp_idx)) begin
         n_fail++;
         $display("FAIL %s.result: got max=%h idx=%0d want max=%h idx=%0d",
                  name, out_max, out_index, exp_max, exp_idx);
      end
      for (int h = 0; h < hold; h++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
             out_max !== exp_max || out_index !== IW'(exp_idx)) begin
            n_fail++;
            $display("FAIL %s.hold%0d: got v=%b rdy=%b busy=%b max=%h idx=%0d want v=1 rdy=0 busy=1 max=%h idx=%0d",
                     name, h, out_valid, in_ready, busy, out_max, out_index, exp_max, exp_idx);
         end
         // Offer samples while the result is pending; none may be taken.
         in_valid = 1'b1;
         in_data  = W'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_max !== exp_max || out_index !== IW'(exp_idx)) begin
         n_fail++;
         $display("FAIL %s.pre_accept: got v=%b max=%h idx=%0d want v=1 max=%h idx=%0d",
                  name, out_valid, out_max, out_index, exp_max, exp_idx);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s.post_accept: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                  name, out_valid, in_ready, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 12'hABC; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          out_max !== '0 || out_index !== '0) begin
         n_fail++;
         $display("FAIL reset: got rdy=%b v=%b busy=%b max=%h idx=%0d want rdy=1 v=0 busy=0 max=0 idx=0",
                  in_ready, out_valid, busy, out_max, out_index);
      end
   endtask

   task automatic test_ascending();
      for (int i = 0; i < N; i++) frame[i] = W'(i);
      run_frame("ascending", 0, 0);
   endtask

   task automatic test_ties();
      for (int i = 0; i < N; i++) frame[i] = 12'h7A5;
      run_frame("all_equal", 0, 0);
      for (int i = 0; i < N; i++) frame[i] = 12'h001;
      frame[5] = 12'hFFF;
      frame[9] = 12'hFFF;
      run_frame("dup_max", 0, 0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) frame[i] = W'($urandom_range(0, 12'hFFE));
      frame[5] = 12'hFFF;
      run_frame("backpressure", 0, 3);
   endtask

   task automatic test_gaps();
      for (int i = 0; i < N; i++) frame[i] = W'(N - 1 - i);
      run_frame("toggle_valid", -1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) frame[i] = W'(1);
      frame[0] = W'(3); frame[1] = W'(9); frame[2] = W'(2);
      run_frame("b2b_first", 0, 0);
      for (int i = 0; i < N; i++) frame[i] = W'(2);
      frame[11] = W'(100);
      run_frame("b2b_second", 0, 0);
      for (int i = 0; i < N; i++) frame[i] = W'($urandom_range(0, 8));
      run_frame("b2b_third", 0, 0);
   endtask

   task automatic test_reset_mid_scan();
      for (int i = 0; i < N; i++) frame[i] = W'($urandom);
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1; in_data = frame[i]; tick();
      end
      in_valid = 1'b0;
      repeat (5) tick();
      n_cmp++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midscan.pre: got busy=%b v=%b want busy=1 v=0", busy, out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_max !== '0) begin
         n_fail++;
         $display("FAIL midscan.after_rst: got rdy=%b busy=%b v=%b max=%h want rdy=1 busy=0 v=0 max=0",
                  in_ready, busy, out_valid, out_max);
      end
      for (int c = 0; c < 15; c++) begin
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan.idle%0d: got v=%b rdy=%b want v=0 rdy=1", c, out_valid, in_ready);
         end
         tick();
      end
      for (int i = 0; i < N; i++) frame[i] = W'($urandom_range(0, 50));
      run_frame("midscan_new", 0, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            frame[i] = (t % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 7));
         end
         run_frame($sformatf("random%0d", t), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_ascending();
      test_ties();
      test_backpressure();
      test_gaps();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/max_scan_ctrl.md
Name: max_scan_ctrl

Overview:
- Sequential max-finder. Collects a frame of N unsigned samples over a valid/ready stream into a local buffer.
- Scans the buffer with a single shared comparator, one compare per cycle, and returns the maximum value and its index.
- Area-reduced alternative to the combinational comparator tree in the Lab 2 datapath; the result interface is the same frame-max.

Parameters:
- N, 12, samples per frame (N >= 2)
- W, 12, sample width in bits
- IW, 4, index width, equal to ceil(log2(N))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  W  unsigned input sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_max  out  W  frame maximum
- out_index  out  IW  position (0..N-1) of the maximum within the frame
- busy  out  1  high in SCAN or DONE

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=LOAD, cnt=0, in_ready=1, out_valid=0, out_max=0, out_index=0, busy=0. Buffer contents are don't-care.
- Reset mid-operation (any state): the partial frame or result is discarded, with no output handshake. The block is in LOAD on the next cycle.
- States: LOAD, SCAN, DONE. All outputs are registered or decoded from state.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: buf[cnt]<=in_data, cnt<=cnt+1.
  - When cnt==0, also max_r<=in_data and idx_r<=0.
  - Accepting sample cnt==N-1 moves to SCAN with k<=1 and cnt<=0.
  - Gaps in in_valid stall the frame without losing state.
- SCAN:
  - in_ready=0.
  - Each cycle the comparator evaluates buf[k] against max_r.
  - If buf[k] > max_r (strictly greater): max_r<=buf[k], idx_r<=k.
  - k<=k+1. When k==N-1, move to DONE after the update.
  - Exactly N-1 cycles.
- DONE:
  - out_valid=1. out_max=max_r, out_index=idx_r, held stable while out_ready=0.
  - in_ready=0.
  - On out_valid&&out_ready: out_valid<=0, move to LOAD.
- Latency: out_valid rises N-1 rising edges after the edge that accepts the last sample (11 for N=12). Minimum frame period is 2N cycles: N load + (N-1) scan + 1 handshake.
- Tie rule: the lowest index wins, because replacement is strict.
- Comparisons are unsigned. No width growth: out_max is W bits.
- No sample is accepted in the same cycle as the result handshake. The first sample of the next frame is accepted at the earliest one cycle after leaving DONE.
- k and cnt never exceed N-1. There is no wrap within a frame; cnt returns to 0 only at frame end or reset.

Decomposition:
- Shared package:
  - state encoding constants LOAD=2'd0, SCAN=2'd1, DONE=2'd2
  - defaults for N, W and IW
- Sub-module `max_cmp`, combinational:
  - inputs a (candidate), b (incumbent)
  - outputs gt = (a > b) and the selected max
  - instantiated once. It is the single shared resource scheduled by the FSM.

Test Plan:
- Ascending frame 0,1,...,11 with continuous in_valid and out_ready=1 -> out_max=11, out_index=11; out_valid high exactly 11 edges after the 12th accept, for one cycle.
- Frame of all 0x7A5 -> out_max=0x7A5, out_index=0 (tie rule). Frame 0xFFF at index 5 and again at index 9, others 0x001 -> out_index=5.
- Max 0xFFF at index 5, out_ready held low 3 cycles after out_valid -> out_max and out_index stable, in_ready=0 and busy=1 throughout; accept on the 4th cycle, then in_ready=1 next cycle.
- in_valid toggled 1,0,0,1,... across the frame (descending 11..0) -> only valid beats stored; out_max=11, out_index=0.
- Two back-to-back frames ({3,9,2,...} then {100 at index 11}) -> results 9 and 100 in order, second frame unaffected by the first's max_r.
- rst asserted for 1 cycle during SCAN at k=6 -> out_valid stays 0, next cycle in LOAD with cnt=0; a new full frame then yields its correct max with no residue.
